// File: rtl/roic_readout_capture.sv
// Readout capture for the 16x16 one-hot row/col matrix scanner.
// Decodes settled positions into an addressed pixel stream with frame status.
module roic_readout_capture #(
    parameter int DATA_W = 12,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              master_rst,
    input  logic              fsync,
    input  logic [15:0]       row,
    input  logic [15:0]       col,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic [3:0]        pix_row,
    output logic [3:0]        pix_col,
    output logic [DATA_W-1:0] pix_out,
    output logic              sof,
    output logic              eof,
    output logic              frame_done,
    output logic              frame_short,
    output logic              seq_err,
    output logic [7:0]        err_count,
    output logic [8:0]        pix_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [2:0] SETTLE_C = 3'(SETTLE);
    // Value loaded at frame start: one past SETTLE so the current
    // position cannot reach SETTLE again; pinned at 7 for SETTLE=7.
    localparam logic [2:0] FORCE_C =
        (SETTLE >= 7) ? 3'd7 : 3'(SETTLE + 1);

    state_t state, state_nxt;

    logic [15:0]       row_q, col_q;
    logic [DATA_W-1:0] data_q;
    logic [31:0]       rc_prev;
    logic [2:0]        stable_cnt;
    logic [7:0]        exp_idx;

    logic       viol, pos, chg, reach;
    logic       cap_evt, cap_ok, last;
    logic [3:0] row_idx, col_idx;

    function automatic logic multi(input logic [15:0] v);
        return (v & (v - 16'd1)) != 16'd0;
    endfunction

    function automatic logic [3:0] enc(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

    // Classify the registered buses and detect the capture event.
    always_comb begin
        viol    = multi(row_q) || multi(col_q);
        pos     = !viol && (row_q != 16'd0) && (col_q != 16'd0);
        chg     = {row_q, col_q} != rc_prev;
        reach   = chg ? (SETTLE_C == 3'd1)
                      : (stable_cnt == SETTLE_C - 3'd1);
        cap_evt = pos && reach && (state == CAPTURE);
        cap_ok  = cap_evt && !fsync;
        last    = cap_ok && (pix_count == 9'd255);
        row_idx = enc(row_q);
        col_idx = enc(col_q);
    end

    // Register the scanner buses and ADC word every cycle.
    always_ff @(posedge clk) begin
        if (master_rst) begin
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
            rc_prev <= '0;
        end else begin
            row_q   <= row;
            col_q   <= col;
            data_q  <= pix_data;
            rc_prev <= {row_q, col_q};
        end
    end

    // Count how long the registered position has been unchanged.
    always_ff @(posedge clk) begin
        if (master_rst) begin
            stable_cnt <= '0;
        end else if (fsync) begin
            stable_cnt <= FORCE_C;
        end else if (chg) begin
            stable_cnt <= 3'd1;
        end else if (stable_cnt != 3'd7) begin
            stable_cnt <= stable_cnt + 3'd1;
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (master_rst) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state decode; frame_done is the DONE state itself.
    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (fsync) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (fsync)     state_nxt = CAPTURE;
                else if (last) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                if (fsync) state_nxt = CAPTURE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pixel strobe, frame markers and per-frame diagnostics.
    always_ff @(posedge clk) begin
        if (master_rst) begin
            pix_valid   <= 1'b0;
            pix_row     <= '0;
            pix_col     <= '0;
            pix_out     <= '0;
            sof         <= 1'b0;
            eof         <= 1'b0;
            frame_short <= 1'b0;
            seq_err     <= 1'b0;
            err_count   <= '0;
            pix_count   <= '0;
            exp_idx     <= '0;
        end else begin
            pix_valid   <= cap_ok;
            eof         <= last;
            sof         <= fsync;
            frame_short <= fsync && (state == CAPTURE)
                           && (pix_count < 9'd256);
            if (cap_ok) begin
                pix_row <= row_idx;
                pix_col <= col_idx;
                pix_out <= data_q;
            end
            if (fsync) begin
                seq_err   <= 1'b0;
                err_count <= '0;
                pix_count <= '0;
                exp_idx   <= '0;
            end else begin
                if (cap_ok) begin
                    pix_count <= pix_count + 9'd1;
                    exp_idx   <= {row_idx, col_idx} + 8'd1;
                    if ({row_idx, col_idx} != exp_idx) seq_err <= 1'b1;
                end
                if (viol && (state == CAPTURE) && (err_count != 8'hFF))
                    err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_roic_readout_capture.sv
// Directed bench for roic_readout_capture with a capture scoreboard.
// Expected pixels are queued at drive time and checked at each strobe.
module tb_roic_readout_capture;

    logic        clk = 1'b0;
    logic        master_rst;
    logic        fsync;
    logic [15:0] row, col;
    logic [11:0] pix_data;
    logic        pix_valid;
    logic [3:0]  pix_row, pix_col;
    logic [11:0] pix_out;
    logic        sof, eof, frame_done, frame_short, seq_err;
    logic [7:0]  err_count;
    logic [8:0]  pix_count;

    always #5 clk = ~clk;

    roic_readout_capture #(.DATA_W(12), .SETTLE(2)) dut (
        .clk        (clk),
        .master_rst (master_rst),
        .fsync      (fsync),
        .row        (row),
        .col        (col),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_row    (pix_row),
        .pix_col    (pix_col),
        .pix_out    (pix_out),
        .sof        (sof),
        .eof        (eof),
        .frame_done (frame_done),
        .frame_short(frame_short),
        .seq_err    (seq_err),
        .err_count  (err_count),
        .pix_count  (pix_count)
    );

    typedef struct packed {
        logic       eof;
        logic       serr;
        logic [3:0] r;
        logic [3:0] c;
        logic [11:0] d;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   m_exp_idx;
    int   m_fcnt;
    logic m_serr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_exp_idx = 0;
        m_fcnt    = 0;
        m_serr    = 1'b0;
    endtask

    task automatic push(input int ri, input int ci);
        exp_t e;
        int idx;
        idx = ri * 16 + ci;
        if (idx != m_exp_idx) m_serr = 1'b1;
        e.r    = 4'(ri);
        e.c    = 4'(ci);
        e.d    = 12'(idx);
        e.serr = m_serr;
        e.eof  = (m_fcnt == 255);
        m_exp_idx = (idx + 1) % 256;
        m_fcnt++;
        q.push_back(e);
    endtask

    task automatic drive(input logic [15:0] r, input logic [15:0] c,
                         input logic [11:0] d, input int n);
        row = r;
        col = c;
        pix_data = d;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pixel(input int ri, input int ci, input int hold,
                         input bit cap);
        if (cap) push(ri, ci);
        drive(16'd1 << ri, 16'd1 << ci, 12'(ri * 16 + ci), hold);
        drive(16'd0, 16'd0, 12'd0, 1);
    endtask

    task automatic do_fsync(input logic short_exp);
        row = '0;
        col = '0;
        fsync = 1'b1;
        @(posedge clk);
        #1;
        fsync = 1'b0;
        chk("sof", 32'(sof), 32'd1);
        chk("frame_short", 32'(frame_short), 32'(short_exp));
        chk("fs_pix_count", 32'(pix_count), 32'd0);
        chk("fs_err_count", 32'(err_count), 32'd0);
        chk("fs_frame_done", 32'(frame_done), 32'd0);
        model_clear();
    endtask

    task automatic frame(input int n, input bit cap);
        for (int i = 0; i < n; i++) pixel(i / 16, i % 16, 3, cap);
    endtask

    // Scoreboard: every strobe must match the oldest queued pixel.
    always @(negedge clk) begin
        if (pix_valid) begin
            exp_t e;
            logic want;
            want = (q.size() != 0);
            chk("strobe_expected", 32'(pix_valid), 32'(want));
            if (want) begin
                e = q.pop_front();
                chk("pix_row", 32'(pix_row), 32'(e.r));
                chk("pix_col", 32'(pix_col), 32'(e.c));
                chk("pix_out", 32'(pix_out), 32'(e.d));
                chk("eof", 32'(eof), 32'(e.eof));
                chk("seq_err", 32'(seq_err), 32'(e.serr));
            end
        end else if (eof) begin
            chk("eof_without_strobe", 32'(eof), 32'd0);
        end
    end

    initial begin
        master_rst = 1'b1;
        fsync = 1'b0;
        row = '0;
        col = '0;
        pix_data = '0;
        model_clear();
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("rst_outputs",
            {pix_valid, sof, eof, frame_done, frame_short, seq_err,
             pix_row, pix_col, pix_out}, 32'd0);
        chk("rst_counts", {err_count, pix_count}, 32'd0);
        master_rst = 1'b0;

        // IDLE: positions tracked but never captured.
        frame(12, 1'b0);
        drive(16'd0, 16'd0, 12'd0, 2);
        chk("idle_pix_count", 32'(pix_count), 32'd0);
        chk("idle_frame_done", 32'(frame_done), 32'd0);

        // Nominal full frame.
        do_fsync(1'b0);
        frame(256, 1'b1);
        drive(16'd0, 16'd0, 12'd0, 2);
        chk("nom_frame_done", 32'(frame_done), 32'd1);
        chk("nom_pix_count", 32'(pix_count), 32'd256);
        chk("nom_seq_err", 32'(seq_err), 32'd0);
        chk("nom_err_count", 32'(err_count), 32'd0);
        chk("nom_drained", 32'(q.size()), 32'd0);

        // Settle filter: 1-cycle position skipped, then seq_err.
        do_fsync(1'b0);
        pixel(0, 0, 3, 1'b1);
        pixel(0, 1, 1, 1'b0);
        pixel(0, 2, 3, 1'b1);
        chk("settle_seq_err", 32'(seq_err), 32'd1);
        chk("settle_count", 32'(pix_count), 32'd2);

        // One-hot violation held 4 cycles.
        drive(16'h0003, 16'h0001, 12'h3, 4);
        drive(16'd0, 16'd0, 12'd0, 1);
        pixel(0, 3, 3, 1'b1);
        chk("viol_err_count", 32'(err_count), 32'd4);
        chk("viol_pix_count", 32'(pix_count), 32'd3);

        // Abort after 100 captures, then a full frame.
        do_fsync(1'b1);
        frame(100, 1'b1);
        chk("abort_count", 32'(pix_count), 32'd100);
        do_fsync(1'b1);
        frame(256, 1'b1);
        drive(16'd0, 16'd0, 12'd0, 2);
        chk("restart_done", 32'(frame_done), 32'd1);
        chk("restart_count", 32'(pix_count), 32'd256);

        // fsync on the capture edge wins.
        do_fsync(1'b0);
        drive(16'd1, 16'd1, 12'd0, 2);
        fsync = 1'b1;
        @(posedge clk);
        #1;
        fsync = 1'b0;
        chk("col_pix_valid", 32'(pix_valid), 32'd0);
        chk("col_sof", 32'(sof), 32'd1);
        chk("col_short", 32'(frame_short), 32'd1);
        model_clear();
        drive(16'd1, 16'd1, 12'd0, 3);
        drive(16'd0, 16'd0, 12'd0, 1);
        chk("col_no_recap", 32'(pix_count), 32'd0);
        pixel(0, 0, 3, 1'b1);
        chk("col_next_cap", 32'(pix_count), 32'd1);

        // master_rst at pixel 50.
        do_fsync(1'b1);
        frame(50, 1'b1);
        row = 16'd1 << 3;
        col = 16'd1 << 2;
        pix_data = 12'd50;
        master_rst = 1'b1;
        @(posedge clk);
        #1;
        master_rst = 1'b0;
        chk("mrst_outputs",
            {pix_valid, sof, eof, frame_done, frame_short, seq_err,
             pix_row, pix_col, pix_out}, 32'd0);
        chk("mrst_counts", {err_count, pix_count}, 32'd0);
        drive(16'd1 << 3, 16'd1 << 2, 12'd50, 3);
        for (int i = 51; i < 58; i++) pixel(i / 16, i % 16, 3, 1'b0);
        chk("mrst_idle_count", 32'(pix_count), 32'd0);
        chk("final_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/roic_readout_capture.md
Name: roic_readout_capture

Overview:
- Receive-side companion to the 16x16 one-hot row/col matrix scanner.
- Watches the scanner's row/col select buses and the frame sync, and decodes each one-hot position into a 4-bit row and 4-bit column index.
- Samples the pixel ADC word once the position has settled, and emits an addressed pixel stream with frame markers, one-hot violation and sequence diagnostics toward the frame buffer.

Parameters:
- DATA_W, 12, pixel ADC word width.
- SETTLE, 2, consecutive cycles a position must be stable on the registered buses before capture (legal range 1..7).

Ports:
- clk  input  1  system clock.
- master_rst  input  1  synchronous, active-high reset.
- fsync  input  1  frame start pulse, same as fed to the scanner.
- row  input  16  one-hot row select from scanner.
- col  input  16  one-hot column select from scanner.
- pix_data  input  DATA_W  ADC sample for the selected pixel.
- pix_valid  output  1  one-cycle strobe, pixel captured.
- pix_row  output  4  row index of captured pixel.
- pix_col  output  4  column index of captured pixel.
- pix_out  output  DATA_W  captured sample.
- sof  output  1  one-cycle start-of-frame pulse.
- eof  output  1  one-cycle pulse coincident with the 256th pix_valid.
- frame_done  output  1  level; high from eof until next sof.
- frame_short  output  1  one-cycle pulse with sof when the previous frame aborted before 256 pixels.
- seq_err  output  1  sticky per frame; a capture arrived out of raster order.
- err_count  output  8  saturating count of one-hot violation cycles this frame.
- pix_count  output  9  pixels captured this frame, 0..256.

Behaviour:
- Reset: all outputs 0. State IDLE. Input registers, stable counter and expected index cleared.
- Input stage: row, col and pix_data are registered every cycle into row_q, col_q and data_q. All decisions use the registered copies; fsync is used unregistered.
- Classification of {row_q, col_q}:
  - GAP: either bus is zero and neither bus has more than one bit set.
  - VIOL: either bus has more than one bit set.
  - POS: both buses are exactly one-hot.
- stable_cnt (3-bit):
  - Loads 1 when {row_q, col_q} differs from its previous registered value.
  - Otherwise increments, saturating at 7.
- Capture event: class is POS, stable_cnt reaches SETTLE on this edge, and state is CAPTURE.
  - Each distinct stable position is captured at most once. Positions held longer do not re-capture.
  - Latency from the row/col input change to pix_valid is SETTLE+1 cycles.
- On a capture, the next cycle shows:
  - pix_valid=1;
  - pix_row/pix_col = encoded indices (bit n gives index n);
  - pix_out = data_q;
  - pix_count incremented.
- pix_row, pix_col and pix_out hold their last captured values between strobes.
- Sequence check:
  - exp_idx (8-bit) is cleared at sof.
  - On each capture, if {pix_row, pix_col} != exp_idx, seq_err is set.
  - exp_idx is then set to {pix_row, pix_col}+1, wrapping at 256 (resynchronises).
  - Raster order is row-major, column fastest.
- VIOL: err_count increments once per VIOL cycle in state CAPTURE, saturating at 255. Never causes a capture.
- State machine:
  - IDLE: fsync -> CAPTURE.
  - CAPTURE: capture #256 -> DONE, with eof=1 in the same cycle as that pix_valid; fsync -> restart CAPTURE.
  - DONE: frame_done=1; fsync -> CAPTURE.
  - In IDLE and DONE, positions are tracked but never captured.
- fsync handling:
  - Next cycle, sof=1.
  - pix_count, err_count, seq_err and exp_idx are cleared.
  - frame_done is cleared.
  - stable_cnt is forced to SETTLE+1 so that a position already on the bus is not captured.
- fsync received while in CAPTURE with pix_count<256: frame_short=1 alongside sof.
- fsync coinciding with a capture event: fsync wins and the capture is discarded.
- master_rst mid-frame: immediate return to the reset state. No eof and no frame_short are generated.

Test Plan:
- Reset then idle: master_rst held 10 cycles, buses zero -> all outputs 0, no pix_valid for 50 cycles.
- Nominal frame: fsync, then 256 positions row-major, each held 3 cycles with 1-cycle zero gaps and pix_data=row_idx*16+col_idx -> sof once; 256 pix_valid with pix_out==pix_row*16+pix_col; eof with the last strobe (15,15); frame_done=1; pix_count=256; seq_err=0; err_count=0.
- Settle filter: SETTLE=2, a position held only 1 cycle between valid ones -> no pix_valid for it, and seq_err=1 on the following capture.
- One-hot violation: row=16'h0003 with col=16'h0001 held 4 cycles mid-frame -> err_count=4, no capture. A subsequent valid position is captured normally.
- Abort and restart: fsync after 100 captures -> frame_short=1 and sof=1 in the same cycle; pix_count=0. A full frame afterwards completes with eof.
- Collision and reset: fsync in the same cycle as a capture event -> no pix_valid, sof=1. master_rst asserted at pixel 50 -> outputs zero next cycle, state IDLE, and positions are ignored until fsync.
